buffer_wr_ctrl: RTL and testbench
=================================

BUFFER_WR_CTRL -- requirements
Module: buffer_wr_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 256, width of one packet word.
REQ-002 Parameter ADDR_WIDTH, default 12, buffer word-address width; equals the free-list manager's address width.
REQ-003 Parameter MAX_PKT_WORDS, default 48, maximum words stored per packet; not greater than the manager's almost-full threshold.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_axis_tdata  input  DATA_WIDTH  incoming packet word.
REQ-007 s_axis_tvalid  input  1  word valid.
REQ-008 s_axis_tlast  input  1  last word of packet.
REQ-009 s_axis_tready  output  1  block accepts word.
REQ-010 s_axis_fl_head  input  ADDR_WIDTH  current free-list head from the address manager.
REQ-011 s_axis_almost_full  input  1  almost-full flag from the address manager.
REQ-012 m_axis_wr_en  output  1  buffer write strobe to the address manager and data RAM.
REQ-013 m_axis_wr_addr  output  ADDR_WIDTH  data RAM write address.
REQ-014 m_axis_wr_data  output  DATA_WIDTH  data RAM write data.
REQ-015 m_axis_desc_valid / m_axis_desc_ready  output / input  1 / 1  descriptor handshake toward the scheduler.
REQ-016 m_axis_desc_sop_addr  output  ADDR_WIDTH  address of the packet's first word.
REQ-017 m_axis_desc_len  output  ADDR_WIDTH  number of stored words, range 1..MAX_PKT_WORDS.
REQ-018 m_axis_desc_trunc  output  1  packet exceeded MAX_PKT_WORDS.
REQ-019 m_axis_drop_cnt / m_axis_pkt_cnt  output  32 / 32  statistics counters.

Function
REQ-020 States: IDLE, WRITE, DROP, DESC.
REQ-021 s_axis_tready is 1 in IDLE, WRITE and DROP, and 0 in DESC.
REQ-022 A beat is tvalid & tready.
REQ-023 IDLE, beat, almost_full=0: write the word; latch sop_addr=fl_head and len=1; go to WRITE, or to DESC if tlast.
REQ-024 IDLE, beat, almost_full=1: discard the entire packet with no writes; increment drop_cnt; go to DROP, or stay in IDLE if tlast.
REQ-025 A write is combinational in the cycle of the beat: wr_en=1, wr_addr=s_axis_fl_head, wr_data=s_axis_tdata; zero latency.
REQ-026 WRITE, beat, len<MAX_PKT_WORDS: write the word and increment len.
REQ-027 WRITE, beat, len=MAX_PKT_WORDS: discard the word with no write and set trunc.
REQ-028 WRITE, beat with tlast: go to DESC.
REQ-029 almost_full is sampled only at SOP; it is ignored mid-packet.
REQ-030 DROP: accept and discard beats with wr_en=0; on tlast go to IDLE.
REQ-031 DESC: desc_valid=1; sop_addr, len and trunc are held stable until desc_ready.
REQ-032 DESC with desc_ready=1: increment pkt_cnt and go to IDLE on the next cycle.
REQ-033 desc_valid first asserts the cycle after the tlast beat.
REQ-034 wr_en is never asserted outside IDLE and WRITE.
REQ-035 len and counters are unsigned; 32-bit counters wrap 0xFFFFFFFF->0.
REQ-036 A beat with tvalid=0 has no effect; tlast, tdata and fl_head are then don't-care.

Reset
REQ-037 rst=1 at a clock edge: state=IDLE, wr_en=0, desc_valid=0, sop_addr=0, len=0, trunc=0, drop_cnt=0, pkt_cnt=0.
REQ-038 Reset mid-packet or mid-descriptor abandons the packet silently; no descriptor is emitted and no counter is updated.
REQ-039 The address manager is reset together with this block.
REQ-040 During rst, s_axis_tready=0.

Configuration
REQ-041 Macro BUFFER_WR_CTRL_STATS_EN defined: drop_cnt and pkt_cnt are implemented per REQ-024, REQ-032 and REQ-035.
REQ-042 BUFFER_WR_CTRL_STATS_EN undefined: no counter registers exist, and m_axis_drop_cnt and m_axis_pkt_cnt are constant 0.

Verification
REQ-043 3-word packet, fl_head 0,1,2 on its beats, almost_full=0, desc_ready=1 -> wr_en on 3 consecutive cycles with addr 0,1,2; desc sop_addr=0, len=3, trunc=0; pkt_cnt=1.
REQ-044 SOP with almost_full=1, 5-word packet -> 0 writes; drop_cnt=1; no descriptor; tready=1 on every beat.
REQ-045 60-word packet, MAX_PKT_WORDS=48 -> 48 writes; desc len=48, trunc=1.
REQ-046 desc_ready held 0 for 10 cycles after EOP -> desc_valid high with fields stable and tready=0 throughout; next packet accepted the cycle after the handshake.
REQ-047 rst pulsed after 2 words of a 4-word packet -> no descriptor; state IDLE; the next packet is processed normally with len correct.
REQ-048 Back-to-back 1-word packets with desc_ready=1 -> desc len=1 per packet; one idle tready=0 cycle between packets.

Source files
------------

// File: rtl/buffer_wr_ctrl.sv
// rtl/buffer_wr_ctrl.sv - packet write controller: stores words at the free-list head and emits one descriptor per packet
// Optional statistics counters: define BUFFER_WR_CTRL_STATS_EN.
module buffer_wr_ctrl #(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 12,
  parameter int MAX_PKT_WORDS = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [ADDR_WIDTH-1:0] s_axis_fl_head,
  input  logic                  s_axis_almost_full,
  output logic                  m_axis_wr_en,
  output logic [ADDR_WIDTH-1:0] m_axis_wr_addr,
  output logic [DATA_WIDTH-1:0] m_axis_wr_data,
  output logic                  m_axis_desc_valid,
  input  logic                  m_axis_desc_ready,
  output logic [ADDR_WIDTH-1:0] m_axis_desc_sop_addr,
  output logic [ADDR_WIDTH-1:0] m_axis_desc_len,
  output logic                  m_axis_desc_trunc,
  output logic [31:0]           m_axis_drop_cnt,
  output logic [31:0]           m_axis_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, WRITE, DROP, DESC} state_e;

  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(MAX_PKT_WORDS);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sop_addr_q, sop_addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic                  trunc_q, trunc_d;
  logic                  beat;
  logic                  drop_sop;
  logic                  desc_done;

  assign s_axis_tready = !rst && (state_q != DESC);
  assign beat          = s_axis_tvalid && s_axis_tready;

  // Writes go straight through in the beat cycle; the manager advances its head on wr_en.
  assign m_axis_wr_addr = s_axis_fl_head;
  assign m_axis_wr_data = s_axis_tdata;

  assign m_axis_desc_sop_addr = sop_addr_q;
  assign m_axis_desc_len      = len_q;
  assign m_axis_desc_trunc    = trunc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sop_addr_q <= '0;
      len_q      <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sop_addr_q <= sop_addr_d;
      len_q      <= len_d;
      trunc_q    <= trunc_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    sop_addr_d        = sop_addr_q;
    len_d             = len_q;
    trunc_d           = trunc_q;
    m_axis_wr_en      = 1'b0;
    m_axis_desc_valid = 1'b0;
    drop_sop          = 1'b0;
    desc_done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (s_axis_almost_full) begin
            drop_sop = 1'b1;
            state_d  = s_axis_tlast ? IDLE : DROP;
          end else begin
            m_axis_wr_en = 1'b1;
            sop_addr_d   = s_axis_fl_head;
            len_d        = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            trunc_d      = 1'b0;
            state_d      = s_axis_tlast ? DESC : WRITE;
          end
        end
      end
      WRITE: begin
        if (beat) begin
          if (len_q < MAX_LEN) begin
            m_axis_wr_en = 1'b1;
            len_d        = len_q + 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
          if (s_axis_tlast) state_d = DESC;
        end
      end
      DROP: begin
        if (beat && s_axis_tlast) state_d = IDLE;
      end
      DESC: begin
        // A reset in this cycle abandons the descriptor, so it must not look valid.
        m_axis_desc_valid = !rst;
        if (m_axis_desc_ready && !rst) begin
          desc_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BUFFER_WR_CTRL_STATS_EN
  logic [31:0] drop_cnt_q;
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      if (drop_sop)  drop_cnt_q <= drop_cnt_q + 32'd1;
      if (desc_done) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
    end
  end

  assign m_axis_drop_cnt = drop_cnt_q;
  assign m_axis_pkt_cnt  = pkt_cnt_q;
`else
  logic unused_stats;
  assign unused_stats    = drop_sop ^ desc_done;
  assign m_axis_drop_cnt = '0;
  assign m_axis_pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_buffer_wr_ctrl.sv
// tb/tb_buffer_wr_ctrl.sv - directed packet-level checks of buffer_wr_ctrl against a per-packet model
module tb_buffer_wr_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int MAX = 48;
`ifdef BUFFER_WR_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic [AW-1:0] fl_head;
  logic          almost_full;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          desc_valid, desc_ready;
  logic [AW-1:0] desc_sop, desc_len;
  logic          desc_trunc;
  logic [31:0]   drop_cnt, pkt_cnt;

  buffer_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKT_WORDS(MAX)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
    .s_axis_fl_head(fl_head), .s_axis_almost_full(almost_full),
    .m_axis_wr_en(wr_en), .m_axis_wr_addr(wr_addr), .m_axis_wr_data(wr_data),
    .m_axis_desc_valid(desc_valid), .m_axis_desc_ready(desc_ready),
    .m_axis_desc_sop_addr(desc_sop), .m_axis_desc_len(desc_len), .m_axis_desc_trunc(desc_trunc),
    .m_axis_drop_cnt(drop_cnt), .m_axis_pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Expected outputs for the current cycle, set by the packet-level stimulus.
  logic          chk_on = 1'b0;
  logic          e_tready, e_wr_en, e_desc_valid, e_trunc;
  logic [AW-1:0] e_wr_addr, e_sop, e_len;
  logic [DW-1:0] e_wr_data;
  int            e_drop = 0;
  int            e_pkt  = 0;
  logic [AW-1:0] cur_head = '0;

  int            wr_total = 0;
  logic [AW-1:0] log_sop[$];
  logic [AW-1:0] log_len[$];
  logic          log_trunc[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("tready", 32'(tready), 32'(e_tready));
      cmp("wr_en", 32'(wr_en), 32'(e_wr_en));
      if (e_wr_en) begin
        cmp("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
        cmp("wr_data", wr_data, e_wr_data);
      end
      cmp("desc_valid", 32'(desc_valid), 32'(e_desc_valid));
      if (e_desc_valid) begin
        cmp("desc_sop", 32'(desc_sop), 32'(e_sop));
        cmp("desc_len", 32'(desc_len), 32'(e_len));
        cmp("desc_trunc", 32'(desc_trunc), 32'(e_trunc));
      end
      cmp("drop_cnt", drop_cnt, STATS ? 32'(e_drop) : 32'd0);
      cmp("pkt_cnt", pkt_cnt, STATS ? 32'(e_pkt) : 32'd0);
      if (wr_en) wr_total++;
      if (desc_valid && desc_ready) begin
        log_sop.push_back(desc_sop);
        log_len.push_back(desc_len);
        log_trunc.push_back(desc_trunc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tvalid = 1'b0; tlast = 1'b0; desc_ready = 1'b0; almost_full = 1'b0;
      e_tready = 1'b1; e_wr_en = 1'b0; e_desc_valid = 1'b0;
      step();
    end
  endtask

  task automatic do_beat(input bit last, input bit af, input bit exp_wr);
    tvalid = 1'b1; tlast = last; tdata = $urandom; fl_head = cur_head; almost_full = af;
    e_tready = 1'b1; e_wr_en = exp_wr; e_desc_valid = 1'b0;
    e_wr_addr = cur_head; e_wr_data = tdata;
    step();
    if (exp_wr) cur_head = cur_head + 1'b1;
  endtask

  // Packet-level model: only the first min(n,MAX) words are stored unless the SOP saw almost_full.
  task automatic send_pkt(input int n, input bit af, input int hold);
    logic [AW-1:0] sop;
    sop = cur_head;
    for (int k = 0; k < n; k++) begin
      do_beat(k == n - 1, (k == 0) ? af : 1'($urandom_range(0, 1)), !af && (k < MAX));
      if (k == 0 && af) e_drop++;
    end
    if (!af) begin
      e_desc_valid = 1'b1; e_tready = 1'b0; e_wr_en = 1'b0;
      e_sop = sop; e_len = AW'((n < MAX) ? n : MAX); e_trunc = (n > MAX);
      tvalid = 1'b1; tlast = 1'b1; tdata = $urandom; almost_full = 1'b0;
      for (int c = 0; c < hold; c++) begin
        desc_ready = 1'b0;
        step();
      end
      desc_ready = 1'b1;
      step();
      e_pkt++;
      desc_ready = 1'b0;
    end
    tvalid = 1'b0;
    e_desc_valid = 1'b0; e_tready = 1'b1; e_wr_en = 1'b0;
  endtask

  initial begin
    int w0;
    int d0;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; fl_head = '0;
    almost_full = 1'b0; desc_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    cmp("rst_tready", 32'(tready), 32'd0);
    cmp("rst_desc_valid", 32'(desc_valid), 32'd0);
    cmp("rst_len", 32'(desc_len), 32'd0);
    cmp("rst_sop", 32'(desc_sop), 32'd0);
    cmp("rst_trunc", 32'(desc_trunc), 32'd0);
    cmp("rst_drop_cnt", drop_cnt, 32'd0);
    cmp("rst_pkt_cnt", pkt_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur_head = '0;
    chk_on = 1'b1;
    idle(2);

    // 3-word packet at heads 0,1,2
    w0 = wr_total;
    send_pkt(3, 1'b0, 0);
    cmp("p3_writes", 32'(wr_total - w0), 32'd3);
    cmp("p3_sop", 32'(log_sop[$]), 32'd0);
    cmp("p3_len", 32'(log_len[$]), 32'd3);
    cmp("p3_trunc", 32'(log_trunc[$]), 32'd0);
    idle(1);

    // almost_full at SOP drops the whole packet
    w0 = wr_total; d0 = log_len.size();
    send_pkt(5, 1'b1, 0);
    cmp("drop_writes", 32'(wr_total - w0), 32'd0);
    cmp("drop_no_desc", 32'(log_len.size() - d0), 32'd0);
    send_pkt(1, 1'b1, 0);
    idle(1);

    // oversize packet is truncated
    w0 = wr_total;
    send_pkt(60, 1'b0, 0);
    cmp("trunc_writes", 32'(wr_total - w0), 32'd48);
    cmp("trunc_len", 32'(log_len[$]), 32'd48);
    cmp("trunc_flag", 32'(log_trunc[$]), 32'd1);

    // descriptor back-pressure, then exactly-MAX packet with no truncation
    send_pkt(2, 1'b0, 10);
    send_pkt(48, 1'b0, 3);
    cmp("max_len", 32'(log_len[$]), 32'd48);
    cmp("max_trunc", 32'(log_trunc[$]), 32'd0);

    // back-to-back single-word packets
    for (int i = 0; i < 4; i++) begin
      send_pkt(1, 1'b0, 0);
      cmp("b2b_len", 32'(log_len[$]), 32'd1);
    end
    idle(2);

    // reset after two words of a four-word packet
    d0 = log_len.size();
    do_beat(1'b0, 1'b0, 1'b1);
    do_beat(1'b0, 1'b0, 1'b1);
    rst = 1'b1; tvalid = 1'b1; tlast = 1'b0;
    e_tready = 1'b0; e_wr_en = 1'b0; e_desc_valid = 1'b0;
    step();
    rst = 1'b0; tvalid = 1'b0;
    cur_head = '0; e_drop = 0; e_pkt = 0;
    e_tready = 1'b1;
    @(negedge clk);
    cmp("rstmid_len", 32'(desc_len), 32'd0);
    cmp("rstmid_sop", 32'(desc_sop), 32'd0);
    cmp("rstmid_no_desc", 32'(log_len.size() - d0), 32'd0);
    @(posedge clk);
    #1;
    idle(1);
    send_pkt(4, 1'b0, 1);
    cmp("after_rst_len", 32'(log_len[$]), 32'd4);
    cmp("after_rst_sop", 32'(log_sop[$]), 32'd0);
    send_pkt(3, 1'b1, 0);
    idle(3);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
